// File: rtl/multiplier_control_if.sv
// Control bus between the add/shift multiplier datapath and its sequencer.
// The sequencer takes the slave view; the datapath (or a bench) takes the master view.
interface multiplier_control_if #(
  parameter int N = 8
);
  localparam int CW = $clog2(N) + 1;

  logic          Run;
  logic          ClearA_LoadB;
  logic          M;
  logic          LdB;
  logic          ClrAX;
  logic          Add_En;
  logic          Sub_En;
  logic          Shift_En;
  logic          Busy;
  logic          Done;
  logic [CW-1:0] Count;

  modport master (
    output Run, ClearA_LoadB, M,
    input  LdB, ClrAX, Add_En, Sub_En, Shift_En, Busy, Done, Count
  );

  modport slave (
    input  Run, ClearA_LoadB, M,
    output LdB, ClrAX, Add_En, Sub_En, Shift_En, Busy, Done, Count
  );
endinterface

// File: rtl/multiplier_control.sv
// Sequencer for a signed (Booth-style sign-corrected) add/shift multiplier over X:A:B.
// Optional macro MULT_CTRL_SKIP_ADD_EN folds the shift into ADD when M=0.
module multiplier_control #(
  parameter int N = 8
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  multiplier_control_if.slave   ctrl_if
);
  localparam int            CW   = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLRA,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic          run_q;
  logic          start;
  logic          in_add;
  logic          last_iter;

  assign start     = ctrl_if.Run & ~run_q;
  assign in_add    = (state_q == ADD);
  assign last_iter = (count_q == LAST);

  // run_q resets high so a Run held through reset cannot look like a rising edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      run_q   <= 1'b1;
    end else begin
      run_q <= ctrl_if.Run;
      case (state_q)
        IDLE: begin
          if (start)                     state_q <= CLRA;
          else if (ctrl_if.ClearA_LoadB) state_q <= LOAD;
        end
        LOAD: state_q <= IDLE;
        CLRA: begin
          count_q <= '0;
          state_q <= ADD;
        end
        ADD: begin
`ifdef MULT_CTRL_SKIP_ADD_EN
          if (!ctrl_if.M) begin
            if (last_iter) begin
              state_q <= DONE;
            end else begin
              count_q <= count_q + 1'b1;
              state_q <= ADD;
            end
          end else begin
            state_q <= SHIFT;
          end
`else
          state_q <= SHIFT;
`endif
        end
        SHIFT: begin
          if (last_iter) begin
            state_q <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
            state_q <= ADD;
          end
        end
        DONE: begin
          if (!ctrl_if.Run) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state register; only ADD also looks at the B shift-out bit.
  assign ctrl_if.LdB    = (state_q == LOAD);
  assign ctrl_if.ClrAX  = (state_q == LOAD) || (state_q == CLRA);
  assign ctrl_if.Add_En = in_add && ctrl_if.M && !last_iter;
  assign ctrl_if.Sub_En = in_add && ctrl_if.M && last_iter;
`ifdef MULT_CTRL_SKIP_ADD_EN
  assign ctrl_if.Shift_En = (state_q == SHIFT) || (in_add && !ctrl_if.M);
`else
  assign ctrl_if.Shift_En = (state_q == SHIFT);
`endif
  assign ctrl_if.Busy   = (state_q == CLRA) || in_add || (state_q == SHIFT);
  assign ctrl_if.Done   = (state_q == DONE);
  assign ctrl_if.Count  = count_q;
endmodule

// File: tb/tb_multiplier_control.sv
// Scoreboard bench: stimulus queues expected control words and products, a monitor pops and compares.
// A small X:A:B datapath in the bench closes the M feedback loop and forms the product.
module tb_multiplier_control;
  localparam int N = 8;

  localparam logic [6:0] V_LOAD = 7'b1100000;
  localparam logic [6:0] V_CLRA = 7'b0100010;
  localparam logic [6:0] V_ADD  = 7'b0010010;
  localparam logic [6:0] V_SUB  = 7'b0001010;
  localparam logic [6:0] V_SHF  = 7'b0000110;
  localparam logic [6:0] V_BUSY = 7'b0000010;
  localparam logic [6:0] V_DONE = 7'b0000001;

  typedef struct {
    logic [6:0] vec;
    bit         chk_cnt;
    int         cnt;
  } exp_t;

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  s;
    int          hold;
    bit          load;
    logic [15:0] prod;
  } op_t;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  multiplier_control_if #(.N(N)) bus ();

  multiplier_control #(.N(N)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .ctrl_if (bus)
  );

  // Datapath model: A, X, B and the switch value that feeds both B (load) and S (add/sub).
  logic [N-1:0] a_r = '0;
  logic         x_r = 1'b0;
  logic [N-1:0] b_r = '0;
  logic [N-1:0] sw  = '0;
  logic [N:0]   sum;

  assign bus.M = b_r[0];

  always @(posedge Clk) begin
    if (bus.ClrAX) begin
      a_r <= '0;
      x_r <= 1'b0;
    end
    if (bus.LdB) b_r <= sw;
    if (bus.Add_En) begin
      sum = {a_r[N-1], a_r} + {sw[N-1], sw};
      {x_r, a_r} <= sum;
    end
    if (bus.Sub_En) begin
      sum = {a_r[N-1], a_r} - {sw[N-1], sw};
      {x_r, a_r} <= sum;
    end
    if (bus.Shift_En) begin
      a_r <= {x_r, a_r[N-1:1]};
      b_r <= {a_r[0], b_r[N-1:1]};
    end
  end

  exp_t        exp_q[$];
  logic [15:0] prod_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got event/timeout, expected none at %0t", name, $time);
  endtask

  function automatic logic [6:0] outs();
    return {bus.LdB, bus.ClrAX, bus.Add_En, bus.Sub_En, bus.Shift_En, bus.Busy, bus.Done};
  endfunction

  // Monitor: every cycle with any control output active is one transaction.
  logic done_prev = 1'b0;
  always @(negedge Clk) begin
    logic [6:0] v;
    exp_t       e;
    v = outs();
    if (v != 7'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ctrl", 32'(v), 32'd0);
      end else begin
        e = exp_q.pop_front();
        $display("txn ctrl=%07b count=%0d expected=%07b", v, bus.Count, e.vec);
        check("ctrl", 32'(v), 32'(e.vec));
        if (e.chk_cnt) check("count", 32'(bus.Count), 32'(e.cnt));
      end
    end
    if (bus.Done && !done_prev) begin
      if (prod_q.size() == 0) fail_now("unexpected_done");
      else check("product", 32'({a_r, b_r}), 32'(prod_q.pop_front()));
    end
    done_prev <= bus.Done;
  end

  task automatic push(input logic [6:0] vec, input bit chk, input int cnt);
    exp_t e;
    e.vec = vec; e.chk_cnt = chk; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic push_mult(input logic [7:0] b, input int hold);
    push(V_CLRA, 1'b0, 0);
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        push((i == N - 1) ? V_SUB : V_ADD, 1'b1, i);
        push(V_SHF, 1'b1, i);
      end else begin
`ifdef MULT_CTRL_SKIP_ADD_EN
        push(V_SHF, 1'b1, i);
`else
        push(V_BUSY, 1'b1, i);
        push(V_SHF, 1'b1, i);
`endif
      end
    end
    for (int k = 0; k <= hold; k++) push(V_DONE, 1'b1, N - 1);
  endtask

  task automatic load_b(input logic [7:0] b);
    sw = b;
    push(V_LOAD, 1'b0, 0);
    bus.ClearA_LoadB = 1'b1;
    @(negedge Clk);
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.Done && t < 200) begin
      @(negedge Clk);
      t++;
    end
    if (!bus.Done) fail_now("done_timeout");
  endtask

  task automatic run_op(input op_t op, input bit with_clb);
    if (op.load) load_b(op.b);
    sw = op.s;
    push_mult(op.b, op.hold);
    prod_q.push_back(op.prod);
    bus.Run = 1'b1;
    if (with_clb) bus.ClearA_LoadB = 1'b1;
    @(negedge Clk);
    wait_done();
    repeat (op.hold) @(negedge Clk);
    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
  endtask

  op_t ops[6];

  initial begin
    ops[0] = '{b: 8'h07, s: 8'h03, hold: 0, load: 1'b1, prod: 16'h0015};
    ops[1] = '{b: 8'hFF, s: 8'h05, hold: 5, load: 1'b1, prod: 16'hFFFB};
    ops[2] = '{b: 8'hFB, s: 8'h05, hold: 0, load: 1'b0, prod: 16'hFFE7};
    ops[3] = '{b: 8'h00, s: 8'h09, hold: 1, load: 1'b1, prod: 16'h0000};
    ops[4] = '{b: 8'h80, s: 8'h80, hold: 0, load: 1'b1, prod: 16'h4000};
    ops[5] = '{b: 8'hFD, s: 8'h04, hold: 2, load: 1'b1, prod: 16'hFFF4};

    Reset_n          = 1'b0;
    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    #1;
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_count", 32'(bus.Count), 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 6; i++) run_op(ops[i], 1'b0);

    // Run and ClearA_LoadB rise together: multiply wins, no LdB, held ClearA_LoadB ignored.
    load_b(8'h05);
    run_op('{b: 8'h05, s: 8'h06, hold: 0, load: 1'b0, prod: 16'h001E}, 1'b1);

    // Held ClearA_LoadB reloads every other cycle.
    sw = 8'h11;
    push(V_LOAD, 1'b0, 0);
    push(V_LOAD, 1'b0, 0);
    bus.ClearA_LoadB = 1'b1;
    repeat (4) @(negedge Clk);
    bus.ClearA_LoadB = 1'b0;
    @(negedge Clk);
    check("held_load_b", 32'(b_r), 32'h11);

    // Reset during ADD at Count=4 with Run held through reset.
    load_b(8'hFF);
    push(V_CLRA, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      push(V_ADD, 1'b1, i);
      push(V_SHF, 1'b1, i);
    end
    push(V_ADD, 1'b1, 4);
    bus.Run = 1'b1;
    begin
      int t = 0;
      while (!(bus.Busy && !bus.Shift_En && bus.Count == 4) && t < 100) begin
        @(negedge Clk);
        t++;
      end
      if (t >= 100) fail_now("add4_timeout");
    end
    #1 Reset_n = 1'b0;
    #1;
    check("abort_outs", 32'(outs()), 32'd0);
    check("abort_count", 32'(bus.Count), 32'd0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    check("no_restart_busy", 32'(bus.Busy), 32'd0);
    bus.Run = 1'b0;
    repeat (3) @(negedge Clk);

    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    check("prod_queue_empty", 32'(prod_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
